// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: ID-stage hazard and stall controller for a 5-stage pipeline.
// Latency: stall/flush decode is combinational in the same cycle. The BR2 and MWAIT
//          sequencing, the wait counter and the timeout flag are registered.
// Backpressure: mem_busy_i holds the whole pipe (pipe_hold_o) and overrides all other stalls.
//
// Ports:
//   clk_i, rst_i        : single clock; synchronous active-high reset
//   id_*_i              : source fields and branch info of the instruction in ID
//   ex_*_i, mem_*_i     : destination/type of the instructions in EX and MEM
//   mem_busy_i          : data memory has not finished the access in MEM
//   pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o, pipe_hold_o : pipeline control
//   timeout_o           : sticky flag, set after MAX_WAIT consecutive busy cycles
//   stall_cycles_o      : count of cycles with pc_write_o=0
//                         (active only when ID_HAZARD_PERF_CNT_EN is defined, else 0)
module id_hazard_ctrl #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  id_rs_i,
    input  logic [4:0]  id_rt_i,
    input  logic        id_uses_rt_i,
    input  logic        id_branch_i,
    input  logic        id_br_taken_i,
    input  logic        ex_regwrite_i,
    input  logic        ex_memread_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        mem_memread_i,
    input  logic [4:0]  mem_rd_i,
    input  logic        mem_busy_i,
    output logic        pc_write_o,
    output logic        ifid_write_o,
    output logic        idex_bubble_o,
    output logic        ifid_flush_o,
    output logic        pipe_hold_o,
    output logic        timeout_o,
    output logic [15:0] stall_cycles_o
);

    typedef enum logic [1:0] {
        S_RUN   = 2'b00,
        S_BR2   = 2'b01,
        S_MWAIT = 2'b10
    } state_e;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_e     state_q, state_d;
    logic       resume_br2_q, resume_br2_d;   // MWAIT must return to BR2, not RUN
    logic [7:0] wait_cnt_q;
    logic [7:0] wait_inc;
    logic       timeout_q;

    // A source matches only if it is nonzero and actually read.
    logic rs_ex_m, rt_ex_m, rs_mem_m, rt_mem_m, ex_match, mem_match;
    logic load_use, br_alu, br_load_ex, br_load_mem, hazard, in_br2;

    always_comb begin
        rs_ex_m     = (id_rs_i != 5'd0) && (id_rs_i == ex_rd_i);
        rt_ex_m     = id_uses_rt_i && (id_rt_i != 5'd0) && (id_rt_i == ex_rd_i);
        rs_mem_m    = (id_rs_i != 5'd0) && (id_rs_i == mem_rd_i);
        rt_mem_m    = id_uses_rt_i && (id_rt_i != 5'd0) && (id_rt_i == mem_rd_i);
        ex_match    = rs_ex_m || rt_ex_m;
        mem_match   = rs_mem_m || rt_mem_m;
        load_use    = ex_memread_i && ex_match;
        br_alu      = id_branch_i && ex_regwrite_i && !ex_memread_i && ex_match;
        br_load_ex  = id_branch_i && ex_memread_i && ex_match;
        br_load_mem = id_branch_i && mem_memread_i && mem_match;
        hazard      = load_use || br_alu || br_load_ex || br_load_mem;
        // A wait that interrupted BR2 still owes the second branch stall once memory is ready.
        in_br2      = (state_q == S_BR2) || ((state_q == S_MWAIT) && resume_br2_q);
    end

    // Output decode and next state. Any encoding other than BR2/MWAIT behaves as RUN.
    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        idex_bubble_o = 1'b0;
        ifid_flush_o  = 1'b0;
        pipe_hold_o   = 1'b0;
        state_d       = S_RUN;
        resume_br2_d  = 1'b0;
        if (rst_i) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end else if (mem_busy_i) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            pipe_hold_o   = 1'b1;
            state_d       = S_MWAIT;
            resume_br2_d  = in_br2;
        end else if (in_br2) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end else if (hazard) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
            // A branch on a load still in EX needs a second stall cycle.
            state_d       = br_load_ex ? S_BR2 : S_RUN;
        end else if (id_branch_i && id_br_taken_i) begin
            ifid_flush_o  = 1'b1;
        end
    end

    // Saturating increment of the consecutive-busy counter.
    assign wait_inc = (wait_cnt_q == 8'hFF) ? 8'hFF : (wait_cnt_q + 8'd1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_RUN;
            resume_br2_q <= 1'b0;
            wait_cnt_q   <= 8'd0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            resume_br2_q <= resume_br2_d;
            wait_cnt_q   <= mem_busy_i ? wait_inc : 8'd0;
            if (mem_busy_i && (wait_inc >= MAX_WAIT_C)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;

`ifdef ID_HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= 16'd0;
        end else if (!pc_write_o) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;   // wraps 0xFFFF -> 0
        end
    end

    assign stall_cycles_o = stall_cnt_q;
`else
    assign stall_cycles_o = 16'd0;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb_id_hazard_ctrl: directed bench for id_hazard_ctrl.
// Instance dut uses the default MAX_WAIT; dut3 uses MAX_WAIT=3. Both share the same inputs.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_id_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
    logic       id_uses_rt, id_branch, id_br_taken, ex_regwrite, ex_memread, mem_memread, mem_busy;

    logic        pc_w, ifid_w, bubble, flush, hold, tmo;
    logic [15:0] stc;
    logic        pc_w3, ifid_w3, bubble3, flush3, hold3, tmo3;
    logic [15:0] stc3;

    int total = 0;
    int bad   = 0;

`ifdef ID_HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    id_hazard_ctrl dut (
        .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
        .id_branch_i(id_branch), .id_br_taken_i(id_br_taken), .ex_regwrite_i(ex_regwrite),
        .ex_memread_i(ex_memread), .ex_rd_i(ex_rd), .mem_memread_i(mem_memread), .mem_rd_i(mem_rd),
        .mem_busy_i(mem_busy), .pc_write_o(pc_w), .ifid_write_o(ifid_w), .idex_bubble_o(bubble),
        .ifid_flush_o(flush), .pipe_hold_o(hold), .timeout_o(tmo), .stall_cycles_o(stc)
    );

    id_hazard_ctrl #(.MAX_WAIT(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
        .id_branch_i(id_branch), .id_br_taken_i(id_br_taken), .ex_regwrite_i(ex_regwrite),
        .ex_memread_i(ex_memread), .ex_rd_i(ex_rd), .mem_memread_i(mem_memread), .mem_rd_i(mem_rd),
        .mem_busy_i(mem_busy), .pc_write_o(pc_w3), .ifid_write_o(ifid_w3), .idex_bubble_o(bubble3),
        .ifid_flush_o(flush3), .pipe_hold_o(hold3), .timeout_o(tmo3), .stall_cycles_o(stc3)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_branch = 1'b0; id_br_taken = 1'b0;
        ex_regwrite = 1'b0; ex_memread = 1'b0; ex_rd = 5'd0;
        mem_memread = 1'b0; mem_rd = 5'd0; mem_busy = 1'b0;
    endtask

    // Checks pc_write, ifid_write, idex_bubble, pipe_hold and ifid_flush of the default instance.
    task automatic chk5(input string tag, input logic e_pc, input logic e_ifid,
                        input logic e_bub, input logic e_hold, input logic e_fl);
        chk({tag, ".pc_write"},    16'(pc_w),   16'(e_pc));
        chk({tag, ".ifid_write"},  16'(ifid_w), 16'(e_ifid));
        chk({tag, ".idex_bubble"}, 16'(bubble), 16'(e_bub));
        chk({tag, ".pipe_hold"},   16'(hold),   16'(e_hold));
        chk({tag, ".ifid_flush"},  16'(flush),  16'(e_fl));
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk); #1;
        chk5("reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("reset.timeout", 16'(tmo), 16'd0);
        chk("reset.stall_cycles", stc, 16'd0);

        @(negedge clk); rst = 1'b0; idle(); #1;
        chk5("idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Load to r0 never causes a hazard.
        @(negedge clk); ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; #1;
        chk5("r0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Load-use on rs: one stall, then the EX bubble releases it.  (stall 1)
        @(negedge clk); ex_rd = 5'd5; id_rs = 5'd5; #1;
        chk5("lu.c0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); ex_memread = 1'b0; ex_regwrite = 1'b0; ex_rd = 5'd0; #1;
        chk5("lu.c1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // rt matches but is not read: no stall.
        @(negedge clk); ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5;
        id_rs = 5'd1; id_rt = 5'd5; id_uses_rt = 1'b0; #1;
        chk("rtgate.pc_write", 16'(pc_w), 16'd1);

        // Branch on a load in EX: two stalls (second one in BR2), then taken flush.  (stalls 2,3)
        @(negedge clk); ex_rd = 5'd3; id_rt = 5'd3; id_uses_rt = 1'b1; id_branch = 1'b1; #1;
        chk5("brld.c0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); ex_memread = 1'b0; ex_regwrite = 1'b0; ex_rd = 5'd0; #1;
        chk5("brld.c1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); id_br_taken = 1'b1; #1;
        chk5("brld.c2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk); idle(); #1;
        chk("brld.c3.ifid_flush", 16'(flush), 16'd0);

        // Branch on an ALU result in EX: one stall, no flush while stalled.  (stall 4)
        @(negedge clk); id_branch = 1'b1; id_br_taken = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd7; id_rs = 5'd7; #1;
        chk5("bralu.c0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); ex_regwrite = 1'b0; ex_rd = 5'd0; #1;
        chk5("bralu.c1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        // Branch on a load in MEM (via rt): one stall.  (stall 5)
        @(negedge clk); idle(); id_branch = 1'b1; mem_memread = 1'b1; mem_rd = 5'd9;
        id_rt = 5'd9; id_uses_rt = 1'b1; id_rs = 5'd2; #1;
        chk5("brmem.c0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); idle(); #1;
        chk("brmem.c1.pc_write", 16'(pc_w), 16'd1);

        // mem_busy overrides a simultaneous load-use hazard and a taken branch.  (stalls 6,7)
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
            id_branch = 1'b1; id_br_taken = 1'b1; mem_busy = 1'b1; #1;
            chk5("busy", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        @(negedge clk); idle(); #1;
        chk5("busy.exit", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("perf7", stc, PERF ? 16'd7 : 16'd0);
        chk("busy2.timeout", 16'(tmo), 16'd0);
        chk("busy2.timeout_mw3", 16'(tmo3), 16'd0);

        // mem_busy during BR2: 4 held cycles, then the owed BR2 stall, then RUN.  (stalls 8..13)
        @(negedge clk); id_branch = 1'b1; ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd4; id_rs = 5'd4; #1;
        chk5("br2busy.enter", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); idle(); mem_busy = 1'b1; #1;
            chk5("br2busy.hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        @(negedge clk); mem_busy = 1'b0; #1;
        chk5("br2busy.resume", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); #1;
        chk5("br2busy.run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("br2busy.timeout", 16'(tmo), 16'd0);
        chk("perf13", stc, PERF ? 16'd13 : 16'd0);

        // Timeout with MAX_WAIT=3: set at the 3rd busy edge, sticky until reset.
        @(negedge clk); rst = 1'b1; idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); rst = 1'b0; mem_busy = 1'b1; #1;
            chk("mw3.timeout", 16'(tmo3), (i >= 3) ? 16'd1 : 16'd0);
            chk("mw3.pipe_hold", 16'(hold3), 16'd1);
        end
        @(negedge clk); mem_busy = 1'b0; #1;
        chk("mw3.sticky", 16'(tmo3), 16'd1);
        chk("mw3.idle.pc_write", 16'(pc_w3), 16'd1);
        @(negedge clk); mem_busy = 1'b1; #1;
        chk("mw3.busy2.pipe_hold", 16'(hold3), 16'd1);
        @(negedge clk); rst = 1'b1; #1;
        chk("mw3.rst.pc_write", 16'(pc_w3), 16'd0);
        chk("mw3.rst.idex_bubble", 16'(bubble3), 16'd1);
        chk("mw3.rst.pipe_hold", 16'(hold3), 16'd0);
        chk("mw3.rst.ifid_flush", 16'(flush3), 16'd0);
        @(negedge clk); rst = 1'b0; mem_busy = 1'b0; #1;
        chk("mw3.after.pc_write", 16'(pc_w3), 16'd1);
        chk("mw3.after.pipe_hold", 16'(hold3), 16'd0);
        chk("mw3.after.timeout", 16'(tmo3), 16'd0);
        chk("mw3.after.stall_cycles", stc3, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
